// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide: radix-2 shift-add and restoring divide, XLEN+2 cycles
// from accept to done (1 for div-by-zero/overflow); starts while busy or in DONE are dropped.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        f3_q;
  logic              neg_q, rneg_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   b_q, quot_q;
  logic [XLEN:0]     rem_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   result_q;

  logic              sgn_a, sgn_b, neg_a, neg_b, div0, ovf;
  logic [XLEN-1:0]   abs_a, abs_b, spec_res;
  logic [XLEN:0]     mul_sum, div_sh, div_tr;
  logic [2*XLEN-1:0] prod_d;
  logic [XLEN-1:0]   quot_d, rem_d, fix_res;

  always_comb begin
    sgn_a    = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
               (funct3_i == 3'b100) || (funct3_i == 3'b110);
    sgn_b    = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
    neg_a    = sgn_a && op_a_i[XLEN-1];
    neg_b    = sgn_b && op_b_i[XLEN-1];
    abs_a    = neg_a ? -op_a_i : op_a_i;
    abs_b    = neg_b ? -op_b_i : op_b_i;
    div0     = funct3_i[2] && (op_b_i == '0);
    ovf      = funct3_i[2] && !funct3_i[0] && (op_a_i == SMIN) && (op_b_i == '1);
    spec_res = '0;
    if (div0)     spec_res = funct3_i[1] ? op_a_i : '1;
    else if (ovf) spec_res = funct3_i[1] ? '0 : op_a_i;

    // Multiplier lives in the low half of prod_q and shifts out LSB first.
    mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : '0);
    div_sh  = {rem_q[XLEN-1:0], quot_q[XLEN-1]};
    div_tr  = div_sh - {1'b0, b_q};

    prod_d  = neg_q ? -prod_q : prod_q;
    quot_d  = neg_q ? -quot_q : quot_q;
    rem_d   = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    case (f3_q)
      3'b000:                 fix_res = prod_d[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_d[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quot_d;
      default:                fix_res = rem_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      prod_q   <= '0;
      b_q      <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            f3_q   <= funct3_i;
            neg_q  <= neg_a ^ neg_b;
            rneg_q <= neg_a;
            cnt_q  <= '0;
            prod_q <= {{XLEN{1'b0}}, abs_b};
            b_q    <= funct3_i[2] ? abs_b : abs_a;
            quot_q <= abs_a;
            rem_q  <= '0;
            busy_q <= 1'b1;
            if (div0 || ovf) begin
              result_q <= spec_res;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (f3_q[2]) begin
            rem_q  <= div_tr[XLEN] ? div_sh : div_tr;
            quot_q <= {quot_q[XLEN-2:0], ~div_tr[XLEN]};
          end else begin
            prod_q <= {mul_sum, prod_q[XLEN-1:1]};
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) state_q <= S_FIXUP;
        end
        S_FIXUP: begin
          result_q <= fix_res;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
